uart_tx_dev_io: RTL

- Memory-mapped UART transmitter on the MIO bus, a peripheral sibling of the LED and seven-segment devices.
- Consumes a bus write strobe plus the Peripheral_in data word that the bus decoder produces.
- Buffers bytes in a FIFO and serialises them 8N1 on a TX pin.
- Returns a status word that the bus decoder multiplexes onto the CPU read-data path.

---
 rtl/uart_tx_dev_io.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_dev_io.sv
// uart_tx_dev_io: memory-mapped 8N1 UART transmitter for the MIO bus.
//
// Ports:
//   clk            system clock, all state on the rising edge
//   rst            asynchronous reset, active low
//   uart_we        one-cycle data write strobe, pushes Peripheral_in[7:0]
//   uart_ctrl_we   one-cycle control write strobe, loads the bit divisor
//                  from Peripheral_in[15:0] and clears the overflow flag
//   Peripheral_in  bus write data
//   status_out     {div[15:0], 4'b0, overflow, busy, empty, full, count[7:0]}
//   txd            serial output, idle high
//   tx_busy        frame in progress
//   fifo_full      transmit FIFO holds DEPTH bytes
module uart_tx_dev_io #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_we,
  input  logic        uart_ctrl_we,
  input  logic [31:0] Peripheral_in,
  output logic [31:0] status_out,
  output logic        txd,
  output logic        tx_busy,
  output logic        fifo_full
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  localparam int unsigned AW        = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic [AW:0] count;
  logic        full, empty, push, pop;

  logic        ovf_q, ovf_d;
  logic [15:0] div_q, div_d;

  state_e      state_q;
  logic [15:0] frame_div_q;
  logic [15:0] baud_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        txd_q;
  logic        baud_wrap;

  logic        unused_bits;
  assign unused_bits = ^Peripheral_in[31:16];

  // Pointers carry one extra bit so full and empty are distinguishable.
  assign count = wptr_q - rptr_q;
  assign full  = (count == DEPTH_CNT);
  assign empty = (count == '0);

  // Fullness is judged before any pop in the same cycle.
  assign push = uart_we && !full;
  assign pop  = (state_q == IDLE) && !empty;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovf_d  = ovf_q;
    div_d  = div_q;
    if (push) wptr_d = wptr_q + (AW + 1)'(1);
    if (pop)  rptr_d = rptr_q + (AW + 1)'(1);
    if (uart_ctrl_we) begin
      ovf_d = 1'b0;
      div_d = (Peripheral_in[15:1] == '0) ? 16'd2 : Peripheral_in[15:0];
    end
    // A dropped push wins over a same-cycle clear.
    if (uart_we && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      ovf_q  <= 1'b0;
      div_q  <= DEFAULT_DIV;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      ovf_q  <= ovf_d;
      div_q  <= div_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= Peripheral_in[7:0];
  end

  assign baud_wrap = (baud_q == frame_div_q - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      frame_div_q <= DEFAULT_DIV;
      baud_q      <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      txd_q       <= 1'b1;
    end else begin
      // txd trails the state by one cycle so the pin comes straight off a flop.
      case (state_q)
        START:   txd_q <= 1'b0;
        DATA:    txd_q <= shift_q[0];
        default: txd_q <= 1'b1;
      endcase

      case (state_q)
        IDLE: begin
          if (pop) begin
            shift_q     <= mem_q[rptr_q[AW-1:0]];
            frame_div_q <= div_q;
            baud_q      <= '0;
            state_q     <= START;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_q == 3'd7) state_q <= STOP;
            else               bit_q   <= bit_q + 3'd1;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_q  <= '0;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign txd        = txd_q;
  assign tx_busy    = (state_q != IDLE);
  assign fifo_full  = full;
  assign status_out = {div_q, 4'b0000, ovf_q, tx_busy, empty, full, 8'(count)};

endmodule
